bcd_seg_scanner: RTL

- Downstream of the binary-to-BCD converter in the frequency counter.
- Takes the 6-digit BCD word (5 integer digits, 1 tenths digit) and drives a time-multiplexed common-anode/cathode 7-segment display.
- Provides a decimal point, leading-zero blanking, an inter-digit ghost-blanking gap, and tear-free updates: a new value is applied only at a frame boundary.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/bcd_to_seg7.sv | 30 +++
 rtl/bcd_seg_scanner.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment encodings and slot timing helpers for the display scanner.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   function automatic int slot_div(input int clk_hz, input int scan_hz);
      return clk_hz / scan_hz;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high segment pattern; non-decimal codes
// render as a dash, and blank forces every segment off.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] pattern
);

   always_comb begin
      pattern = SEG_OFF;
      if (!blank) begin
         case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed 6-digit 7-segment driver with leading-zero blanking,
// ghost-blanking gap per slot and frame-aligned (tear-free) value updates.
module bcd_seg_scanner
   import seg7_pkg::*;
#(
   parameter int CLK_HZ         = 50000000,
   parameter int SCAN_HZ        = 1000,
   parameter int BLANK_CYC      = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] bcd_in,
   input  logic        bcd_valid,
   input  logic        blank_lz,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [5:0]  dig_sel,
   output logic        frame_start
);

   localparam int DIV   = slot_div(CLK_HZ, SCAN_HZ);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
   localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic       DP_INV  = SEG_ACTIVE_LOW;
   localparam logic [5:0] DIG_INV = DIG_ACTIVE_LOW ? 6'h3F : 6'h00;

   generate
      if (DIV < BLANK_CYC + 2) begin : g_div_check
         $error("bcd_seg_scanner: slot of %0d cycles too short for %0d blank cycles", DIV, BLANK_CYC);
      end
   endgenerate

   logic [CNT_W-1:0] cnt_p0;
   logic [2:0]       idx_p0;
   logic [23:0]      shadow;
   logic [23:0]      display;
   logic             pending;
   logic             slot_wrap;
   logic             frame_wrap;
   logic [5:0]       lz_blank;
   logic [3:0]       nib_sel;
   logic             blk_sel;
   logic [6:0]       pat;

   assign slot_wrap  = (cnt_p0 == CNT_MAX);
   assign frame_wrap = slot_wrap && (idx_p0 == 3'd5);

   // Stage p0: prescaler, digit index and frame-aligned display capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p0      <= '0;
         idx_p0      <= '0;
         shadow      <= '0;
         display     <= '0;
         pending     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= frame_wrap;
         if (slot_wrap) begin
            cnt_p0 <= '0;
            idx_p0 <= frame_wrap ? 3'd0 : idx_p0 + 3'd1;
         end else begin
            cnt_p0 <= cnt_p0 + 1'b1;
         end
         if (bcd_valid)
            shadow <= bcd_in;
         // A strobe coinciding with the wrap bypasses the shadow so it is not lost
         if (frame_wrap && (pending || bcd_valid)) begin
            display <= bcd_valid ? bcd_in : shadow;
            pending <= 1'b0;
         end else if (bcd_valid) begin
            pending <= 1'b1;
         end
      end
   end

   always_comb begin
      lz_blank    = '0;
      lz_blank[5] = blank_lz && (display[23:20] == 4'd0);
      lz_blank[4] = lz_blank[5] && (display[19:16] == 4'd0);
      lz_blank[3] = lz_blank[4] && (display[15:12] == 4'd0);
      lz_blank[2] = lz_blank[3] && (display[11:8] == 4'd0);
   end

   always_comb begin
      nib_sel = display[3:0];
      blk_sel = 1'b0;
      case (idx_p0)
         3'd1: nib_sel = display[7:4];
         3'd2: begin nib_sel = display[11:8];  blk_sel = lz_blank[2]; end
         3'd3: begin nib_sel = display[15:12]; blk_sel = lz_blank[3]; end
         3'd4: begin nib_sel = display[19:16]; blk_sel = lz_blank[4]; end
         3'd5: begin nib_sel = display[23:20]; blk_sel = lz_blank[5]; end
         default: ;
      endcase
   end

   bcd_to_seg7 u_dec (
      .nibble  (nib_sel),
      .blank   (blk_sel),
      .pattern (pat)
   );

   // Stage p1: registered outputs, polarity applied only here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg     <= SEG_INV;
         dp      <= DP_INV;
         dig_sel <= DIG_INV;
      end else if (cnt_p0 < BLANK_END) begin
         seg     <= SEG_INV;
         dp      <= DP_INV;
         dig_sel <= DIG_INV;
      end else begin
         seg     <= pat ^ SEG_INV;
         dp      <= (idx_p0 == 3'd1) ^ DP_INV;
         dig_sel <= (6'b000001 << idx_p0) ^ DIG_INV;
      end
   end

endmodule
